fx2_out_arbiter: RTL
====================

# fx2_out_arbiter

Shares the FX2 slave-FIFO bus in fx2_timetag between three requesters: the register reply path, the command reader and the sample record stream. Serializes 32-bit register replies (LSB first) and 48-bit timetag records (MSB first) onto the 8-bit FX2 data bus with endpoint selection, full-flag backpressure and packet-end commits. Grants the bus to the command reader when no reply is pending. Sits between the register/capture logic and the FX2 pins.

## Interface
- SAMPLE_ADR, 2'b10, fifoadr of sample IN endpoint (EP6)
- REPLY_ADR, 2'b11, fifoadr of reply IN endpoint (EP8)
- CMD_ADR, 2'b00, fifoadr of command OUT endpoint (EP2)
- FLUSH_CYCLES, 1024, idle cycles before a partial sample packet is committed (≥2)
- fx2_clk  in  1  FX2 interface clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- reply_data  in  32  register reply word
- reply_valid  in  1  reply pending; held until reply_ack
- reply_ack  out  1  one-cycle pulse: reply latched
- sample_data  in  48  timetag record
- sample_valid  in  1  record pending; held until sample_ack
- sample_ack  out  1  one-cycle pulse: record latched
- cmd_req  in  1  command reader requests the bus
- cmd_gnt  out  1  bus owned by command reader (fifoadr = CMD_ADR, fd_oe = 0)
- fx2_full_n  in  1  full flag (active low) of the addressed FIFO
- fx2_fd  out  8  write data
- fx2_fd_oe  out  1  drive fx2_fd onto pins
- fx2_slwr_n  out  1  write strobe, active low
- fx2_pktend_n  out  1  packet end, active low
- fx2_fifoadr  out  2  endpoint select

## Operation
- States: IDLE, GRANT, SETTLE, SEND, COMMIT.
- IDLE priority: reply_valid > cmd_req > sample_valid > flush. Evaluated only in IDLE; records never interleave.
- Reply/sample selected: latch word into shift register, pulse ack same cycle, set fifoadr, go SETTLE. Byte count 4 (reply) or 6 (sample).
- SETTLE: one cycle, fifoadr stable, fd_oe=1; go SEND.
- SEND: if fx2_full_n=1, drive next byte, slwr_n=0, decrement count; else slwr_n=1, hold byte (stall unbounded). After last byte: reply -> COMMIT; sample -> IDLE, set sample_dirty.
- COMMIT: pktend_n=0 one cycle, slwr_n=1, clear dirty for that endpoint; -> IDLE.
- Flush: idle_cnt increments each IDLE cycle with no request while sample_dirty=1, clears on any sample write. At FLUSH_CYCLES, select SAMPLE_ADR, SETTLE, COMMIT (zero-length-safe: only when dirty).
- GRANT: cmd_gnt=1, fifoadr=CMD_ADR, fd_oe=0, slwr_n=1; stays until cmd_req=0, then IDLE next cycle. reply_valid does not preempt GRANT.
- Byte order: reply [7:0],[15:8],[23:16],[31:24]; sample [47:40] … [7:0].

## Timing
- Reset values: fx2_fd=0, fx2_fd_oe=0, fx2_slwr_n=1, fx2_pktend_n=1, fx2_fifoadr=SAMPLE_ADR, acks=0, cmd_gnt=0, sample_dirty=0, idle_cnt=0, state IDLE.
- All outputs registered. Request seen in IDLE at edge N: ack high after N, first slwr_n low after N+2 (no stall).
- Unstalled reply: 4 write cycles + 1 pktend cycle; total IDLE-to-IDLE 7 cycles. Sample: 6 writes, 8 cycles.
- fx2_full_n sampled each SEND cycle; deassertion mid-record stalls, never drops or duplicates bytes.
- reply_valid and sample_valid same cycle: reply served; sample served next IDLE.
- Requester must drop valid the cycle after ack; valid held past ack is a new request.
- idle_cnt saturates at FLUSH_CYCLES; width ceil(log2(FLUSH_CYCLES+1)).
- reset_n asserted mid-record: immediate return to reset values; partial record discarded, no pktend.

## Test plan
- Reply 0x12345678, full_n=1 -> fifoadr=3, writes 78,56,34,12 on consecutive cycles, then pktend_n low one cycle.
- Sample 0x0123456789AB -> fifoadr=2, writes 01,23,45,67,89,AB, no pktend; after FLUSH_CYCLES idle cycles, one pktend on fifoadr=2.
- Reply and sample valid same cycle -> full reply with pktend first, then sample; acks in that order.
- full_n low 5 cycles after third sample byte -> slwr_n high 5 cycles, remaining 3 bytes intact, 6 writes total.
- cmd_req held 20 cycles while reply arrives -> cmd_gnt=1, fd_oe=0 for 20 cycles; reply starts 1 cycle after cmd_req falls.
- reset_n low during byte 3 of a reply -> all outputs at reset values within same cycle; no pktend; next reply sent complete.

Source files
------------

// File: rtl/fx2_out_arbiter.sv
// FX2 slave-FIFO bus arbiter: serializes register replies and timetag records
// onto the 8-bit FX2 data bus and hands the bus to the command reader.
module fx2_out_arbiter #(
    parameter logic [1:0]  SAMPLE_ADR   = 2'b10,
    parameter logic [1:0]  REPLY_ADR    = 2'b11,
    parameter logic [1:0]  CMD_ADR      = 2'b00,
    parameter int unsigned FLUSH_CYCLES = 1024
) (
    input  logic        fx2_clk,
    input  logic        reset_n,
    input  logic [31:0] reply_data,
    input  logic        reply_valid,
    output logic        reply_ack,
    input  logic [47:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ack,
    input  logic        cmd_req,
    output logic        cmd_gnt,
    input  logic        fx2_full_n,
    output logic [7:0]  fx2_fd,
    output logic        fx2_fd_oe,
    output logic        fx2_slwr_n,
    output logic        fx2_pktend_n,
    output logic [1:0]  fx2_fifoadr
);

    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_MAX = CW'(FLUSH_CYCLES);

    typedef enum logic [2:0] {IDLE, GRANT, SETTLE, SEND, COMMIT} state_t;

    state_t          state;
    logic [47:0]     shreg;
    logic [2:0]      bytes_left;
    logic            is_reply;
    logic            is_flush;
    logic            sample_dirty;
    logic [CW-1:0]   idle_cnt;

    always_ff @(posedge fx2_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shreg        <= '0;
            bytes_left   <= '0;
            is_reply     <= 1'b0;
            is_flush     <= 1'b0;
            sample_dirty <= 1'b0;
            idle_cnt     <= '0;
            reply_ack    <= 1'b0;
            sample_ack   <= 1'b0;
            cmd_gnt      <= 1'b0;
            fx2_fd       <= '0;
            fx2_fd_oe    <= 1'b0;
            fx2_slwr_n   <= 1'b1;
            fx2_pktend_n <= 1'b1;
            fx2_fifoadr  <= SAMPLE_ADR;
        end else begin
            reply_ack    <= 1'b0;
            sample_ack   <= 1'b0;
            fx2_slwr_n   <= 1'b1;
            fx2_pktend_n <= 1'b1;
            case (state)
                IDLE: begin
                    fx2_fd_oe <= 1'b0;
                    if (reply_valid) begin
                        // Byte-swapped on load so both record types shift out MSB first.
                        shreg       <= {reply_data[7:0], reply_data[15:8],
                                        reply_data[23:16], reply_data[31:24], 16'h0000};
                        bytes_left  <= 3'd4;
                        is_reply    <= 1'b1;
                        is_flush    <= 1'b0;
                        reply_ack   <= 1'b1;
                        fx2_fifoadr <= REPLY_ADR;
                        fx2_fd_oe   <= 1'b1;
                        state       <= SETTLE;
                    end else if (cmd_req) begin
                        cmd_gnt     <= 1'b1;
                        fx2_fifoadr <= CMD_ADR;
                        state       <= GRANT;
                    end else if (sample_valid) begin
                        shreg       <= sample_data;
                        bytes_left  <= 3'd6;
                        is_reply    <= 1'b0;
                        is_flush    <= 1'b0;
                        sample_ack  <= 1'b1;
                        fx2_fifoadr <= SAMPLE_ADR;
                        fx2_fd_oe   <= 1'b1;
                        state       <= SETTLE;
                    end else if (sample_dirty) begin
                        if (idle_cnt == FLUSH_MAX) begin
                            is_reply    <= 1'b0;
                            is_flush    <= 1'b1;
                            fx2_fifoadr <= SAMPLE_ADR;
                            fx2_fd_oe   <= 1'b1;
                            state       <= SETTLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                GRANT: begin
                    if (!cmd_req) begin
                        cmd_gnt <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SETTLE: begin
                    state <= is_flush ? COMMIT : SEND;
                end
                SEND: begin
                    if (fx2_full_n) begin
                        fx2_fd     <= shreg[47:40];
                        shreg      <= {shreg[39:0], 8'h00};
                        fx2_slwr_n <= 1'b0;
                        bytes_left <= bytes_left - 1'b1;
                        if (!is_reply) begin
                            idle_cnt <= '0;
                        end
                        if (bytes_left == 3'd1) begin
                            if (is_reply) begin
                                state <= COMMIT;
                            end else begin
                                sample_dirty <= 1'b1;
                                state        <= IDLE;
                            end
                        end
                    end
                end
                COMMIT: begin
                    fx2_pktend_n <= 1'b0;
                    if (!is_reply) begin
                        sample_dirty <= 1'b0;
                        idle_cnt     <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
